// File: rtl/soc_bus_pkg.sv
// soc_bus_pkg: shared types and encodings for the runtime-programmable address map.
//   rule_t       : one crossbar decode rule {idx, start_addr, end_addr} at default sizes
//   Field*       : field selector in the low two bits of the config address
//   Ctrl*        : bit positions in a CTRL write
//   Status*      : bit positions in a STATUS read
//   map_state_e  : commit sequencer states
//   cnt_w()      : width of the outstanding-transaction counter
package soc_bus_pkg;

    localparam int unsigned AxiAwDef  = 64;
    localparam int unsigned IdxWDef   = 3;

    typedef struct packed {
        logic [IdxWDef-1:0]  idx;
        logic [AxiAwDef-1:0] start_addr;
        logic [AxiAwDef-1:0] end_addr;
    } rule_t;

    localparam logic [1:0] FieldStart = 2'd0;
    localparam logic [1:0] FieldEnd   = 2'd1;
    localparam logic [1:0] FieldCfg   = 2'd2;

    localparam int unsigned CtrlCommitBit = 0;
    localparam int unsigned CtrlClearBit  = 1;

    localparam int unsigned StatusBusyBit     = 0;
    localparam int unsigned StatusRangeErrBit = 1;
    localparam int unsigned StatusCntErrBit   = 2;
    localparam int unsigned StatusCntLsb      = 3;

    typedef enum logic [1:0] {
        StIdle,
        StDrain,
        StSwap
    } map_state_e;

    // Counter must hold 0..2*max_txns inclusive.
    function automatic int unsigned cnt_w(input int unsigned max_txns);
        return $clog2(2 * max_txns + 1);
    endfunction

endpackage

// File: rtl/soc_bus_txn_cnt.sv
// soc_bus_txn_cnt: saturating up/down counter of outstanding AXI transactions.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   inc_a_i, inc_b_i      : +1 each (AW / AR accepted)
//   dec_a_i, dec_b_i      : -1 each (B / last R accepted)
//   clr_err_i             : clear the sticky error flag
//   cnt_o                 : current count, 0..2*MAX_TXNS
//   err_o                 : sticky flag, set on any saturation
module soc_bus_txn_cnt
    import soc_bus_pkg::*;
#(
    parameter int unsigned MAX_TXNS = 16,
    localparam int unsigned CNT_W = cnt_w(MAX_TXNS)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_a_i,
    input  logic             inc_b_i,
    input  logic             dec_a_i,
    input  logic             dec_b_i,
    input  logic             clr_err_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             err_o
);

    // Two spare bits: one for the +2 headroom, one as sign for the -2 case.
    localparam int unsigned SumW = CNT_W + 2;
    localparam logic [SumW-1:0] MaxCnt = SumW'(2 * MAX_TXNS);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [SumW-1:0]  sum;
    logic             underflow;
    logic             overflow;

    always_comb begin
        sum = SumW'(cnt_q) + SumW'(inc_a_i) + SumW'(inc_b_i)
            - SumW'(dec_a_i) - SumW'(dec_b_i);
        underflow = sum[SumW-1];
        overflow  = !underflow && (sum > MaxCnt);

        cnt_d = sum[CNT_W-1:0];
        if (underflow) begin
            cnt_d = '0;
        end else if (overflow) begin
            cnt_d = MaxCnt[CNT_W-1:0];
        end

        // A new error in the same cycle as a clear still wins.
        err_d = err_q;
        if (clr_err_i) begin
            err_d = 1'b0;
        end
        if (underflow || overflow) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign cnt_o = cnt_q;
    assign err_o = err_q;

endmodule

// File: rtl/soc_bus_addr_map.sv
// soc_bus_addr_map: shadow/active address map for the SoC crossbar.
//   clk_i, rst_i                 : clock, synchronous active-high reset
//   cfg_valid_i / cfg_ready_o    : config request handshake (writes blocked while committing)
//   cfg_write_i, cfg_addr_i,
//   cfg_wdata_i                  : config op; addr = {rule, field}, 4*N_RULES is CTRL/STATUS
//   cfg_rdata_o / cfg_rvalid_o   : read data, one cycle after the read is accepted
//   aw_hs_i, ar_hs_i             : new transaction accepted
//   b_hs_i, rlast_hs_i           : transaction retired
//   stall_o                      : block new AW/AR while draining and swapping
//   addr_map_o, rule_valid_o     : active rule table, rule r at [r*RULE_W +: RULE_W]
//                                  laid out as {idx, start_addr, end_addr}
//   commit_done_o                : one-cycle pulse when shadow has been copied to active
module soc_bus_addr_map
    import soc_bus_pkg::*;
#(
    parameter int unsigned AXI_AW      = 64,
    parameter int unsigned N_MST_PORTS = 8,
    parameter int unsigned N_RULES     = 16,
    parameter int unsigned MAX_TXNS    = 16,
    parameter int unsigned DEFAULT_IDX = 0,
    localparam int unsigned IDX_W  = $clog2(N_MST_PORTS),
    localparam int unsigned CNT_W  = cnt_w(MAX_TXNS),
    localparam int unsigned CFG_AW = $clog2(4 * N_RULES + 1),
    localparam int unsigned RULE_W = IDX_W + 2 * AXI_AW
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      cfg_valid_i,
    output logic                      cfg_ready_o,
    input  logic                      cfg_write_i,
    input  logic [CFG_AW-1:0]         cfg_addr_i,
    input  logic [AXI_AW-1:0]         cfg_wdata_i,
    output logic [AXI_AW-1:0]         cfg_rdata_o,
    output logic                      cfg_rvalid_o,
    input  logic                      aw_hs_i,
    input  logic                      ar_hs_i,
    input  logic                      b_hs_i,
    input  logic                      rlast_hs_i,
    output logic                      stall_o,
    output logic [N_RULES*RULE_W-1:0] addr_map_o,
    output logic [N_RULES-1:0]        rule_valid_o,
    output logic                      commit_done_o
);

    localparam int unsigned RIDX_W = $clog2(N_RULES);
    localparam int unsigned SEL_W  = CFG_AW - 2;

    // Shadow (software-visible) and active (decoder-visible) tables.
    logic [AXI_AW-1:0] sh_start_q  [N_RULES];
    logic [AXI_AW-1:0] sh_end_q    [N_RULES];
    logic [IDX_W-1:0]  sh_idx_q    [N_RULES];
    logic              sh_valid_q  [N_RULES];
    logic [AXI_AW-1:0] act_start_q [N_RULES];
    logic [AXI_AW-1:0] act_end_q   [N_RULES];
    logic [IDX_W-1:0]  act_idx_q   [N_RULES];
    logic              act_valid_q [N_RULES];

    map_state_e        state_q, state_d;
    logic              stall_q;
    logic              done_q;
    logic              range_err_q, range_err_d;
    logic [AXI_AW-1:0] rdata_q;
    logic              rvalid_q;

    logic [SEL_W-1:0]  sel_rule;
    logic [1:0]        sel_field;
    logic [RIDX_W-1:0] rule_idx;
    logic              is_rule;
    logic              is_ctrl;
    logic              cfg_wr_acc;
    logic              cfg_rd_acc;
    logic              commit_req;
    logic              clear_req;
    logic              range_bad;
    logic [AXI_AW-1:0] rd_data;
    logic [CNT_W-1:0]  txn_cnt;
    logic              cnt_err;

    // Address decode
    assign sel_rule  = cfg_addr_i[CFG_AW-1:2];
    assign sel_field = cfg_addr_i[1:0];
    assign rule_idx  = sel_rule[RIDX_W-1:0];
    assign is_rule   = (sel_rule < SEL_W'(N_RULES));
    assign is_ctrl   = (cfg_addr_i == CFG_AW'(4 * N_RULES));

    // Shadow is frozen while a commit is in flight, so only writes are back-pressured.
    assign cfg_ready_o = !(cfg_write_i && (state_q != StIdle));
    assign cfg_wr_acc  = cfg_valid_i && cfg_write_i && cfg_ready_o;
    assign cfg_rd_acc  = cfg_valid_i && !cfg_write_i;
    assign commit_req  = cfg_wr_acc && is_ctrl && cfg_wdata_i[CtrlCommitBit];
    assign clear_req   = cfg_wr_acc && is_ctrl && cfg_wdata_i[CtrlClearBit];

    soc_bus_txn_cnt #(
        .MAX_TXNS (MAX_TXNS)
    ) u_txn_cnt (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .inc_a_i   (aw_hs_i),
        .inc_b_i   (ar_hs_i),
        .dec_a_i   (b_hs_i),
        .dec_b_i   (rlast_hs_i),
        .clr_err_i (clear_req),
        .cnt_o     (txn_cnt),
        .err_o     (cnt_err)
    );

    // Only rules that would be enabled can make a commit illegal.
    always_comb begin
        range_bad = 1'b0;
        for (int i = 0; i < N_RULES; i++) begin
            if (sh_valid_q[i] && (sh_start_q[i] > sh_end_q[i])) begin
                range_bad = 1'b1;
            end
        end
    end

    // Commit sequencer
    always_comb begin
        state_d     = state_q;
        range_err_d = range_err_q;
        if (clear_req) begin
            range_err_d = 1'b0;
        end
        unique case (state_q)
            StIdle: begin
                if (commit_req) begin
                    if (range_bad) begin
                        range_err_d = 1'b1;
                    end else begin
                        state_d = StDrain;
                    end
                end
            end
            // A handshake in this cycle means the counter is about to go non-zero.
            StDrain: begin
                if ((txn_cnt == '0) && !aw_hs_i && !ar_hs_i) begin
                    state_d = StSwap;
                end
            end
            StSwap:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            stall_q     <= 1'b0;
            done_q      <= 1'b0;
            range_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            stall_q     <= (state_d != StIdle);
            done_q      <= (state_q == StSwap);
            range_err_q <= range_err_d;
        end
    end

    // Shadow table
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < N_RULES; i++) begin
                sh_start_q[i] <= '0;
                sh_end_q[i]   <= '0;
                sh_idx_q[i]   <= '0;
                sh_valid_q[i] <= 1'b0;
            end
            sh_end_q[0]   <= '1;
            sh_idx_q[0]   <= IDX_W'(DEFAULT_IDX);
            sh_valid_q[0] <= 1'b1;
        end else if (cfg_wr_acc && is_rule) begin
            case (sel_field)
                FieldStart: sh_start_q[rule_idx] <= cfg_wdata_i;
                FieldEnd:   sh_end_q[rule_idx]   <= cfg_wdata_i;
                FieldCfg: begin
                    sh_idx_q[rule_idx]   <= cfg_wdata_i[IDX_W-1:0];
                    sh_valid_q[rule_idx] <= cfg_wdata_i[IDX_W];
                end
                default: ;
            endcase
        end
    end

    // Active table: only ever changes on reset or in the single SWAP cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < N_RULES; i++) begin
                act_start_q[i] <= '0;
                act_end_q[i]   <= '0;
                act_idx_q[i]   <= '0;
                act_valid_q[i] <= 1'b0;
            end
            act_end_q[0]   <= '1;
            act_idx_q[0]   <= IDX_W'(DEFAULT_IDX);
            act_valid_q[0] <= 1'b1;
        end else if (state_q == StSwap) begin
            for (int i = 0; i < N_RULES; i++) begin
                act_start_q[i] <= sh_start_q[i];
                act_end_q[i]   <= sh_end_q[i];
                act_idx_q[i]   <= sh_idx_q[i];
                act_valid_q[i] <= sh_valid_q[i];
            end
        end
    end

    // Read mux; unmapped addresses and the spare field read as zero.
    always_comb begin
        rd_data = '0;
        if (is_ctrl) begin
            rd_data[StatusBusyBit]          = (state_q != StIdle);
            rd_data[StatusRangeErrBit]      = range_err_q;
            rd_data[StatusCntErrBit]        = cnt_err;
            rd_data[StatusCntLsb +: CNT_W]  = txn_cnt;
        end else if (is_rule) begin
            case (sel_field)
                FieldStart: rd_data = sh_start_q[rule_idx];
                FieldEnd:   rd_data = sh_end_q[rule_idx];
                FieldCfg:   rd_data[IDX_W:0] = {sh_valid_q[rule_idx], sh_idx_q[rule_idx]};
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= cfg_rd_acc;
            if (cfg_rd_acc) begin
                rdata_q <= rd_data;
            end
        end
    end

    for (genvar g = 0; g < N_RULES; g++) begin : g_map_out
        assign addr_map_o[g*RULE_W +: RULE_W] = {act_idx_q[g], act_start_q[g], act_end_q[g]};
        assign rule_valid_o[g]                = act_valid_q[g];
    end

    assign cfg_rdata_o   = rdata_q;
    assign cfg_rvalid_o  = rvalid_q;
    assign stall_o       = stall_q;
    assign commit_done_o = done_q;

endmodule

// File: tb/tb_soc_bus_addr_map.sv
module tb_soc_bus_addr_map;
    import soc_bus_pkg::*;

    localparam int unsigned AXI_AW      = 64;
    localparam int unsigned N_MST_PORTS = 8;
    localparam int unsigned N_RULES     = 16;
    localparam int unsigned MAX_TXNS    = 16;
    localparam int unsigned DEFAULT_IDX = 0;
    localparam int unsigned IDX_W       = 3;
    localparam int unsigned CFG_AW      = 7;
    localparam int unsigned RULE_W      = IDX_W + 2 * AXI_AW;
    localparam logic [CFG_AW-1:0] CTRL_ADDR = 7'd64;

    logic                      clk_i = 1'b0;
    logic                      rst_i;
    logic                      cfg_valid_i;
    logic                      cfg_ready_o;
    logic                      cfg_write_i;
    logic [CFG_AW-1:0]         cfg_addr_i;
    logic [AXI_AW-1:0]         cfg_wdata_i;
    logic [AXI_AW-1:0]         cfg_rdata_o;
    logic                      cfg_rvalid_o;
    logic                      aw_hs_i, ar_hs_i, b_hs_i, rlast_hs_i;
    logic                      stall_o;
    logic [N_RULES*RULE_W-1:0] addr_map_o;
    logic [N_RULES-1:0]        rule_valid_o;
    logic                      commit_done_o;

    always #5 clk_i = ~clk_i;

    soc_bus_addr_map #(
        .AXI_AW      (AXI_AW),
        .N_MST_PORTS (N_MST_PORTS),
        .N_RULES     (N_RULES),
        .MAX_TXNS    (MAX_TXNS),
        .DEFAULT_IDX (DEFAULT_IDX)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .cfg_valid_i   (cfg_valid_i),
        .cfg_ready_o   (cfg_ready_o),
        .cfg_write_i   (cfg_write_i),
        .cfg_addr_i    (cfg_addr_i),
        .cfg_wdata_i   (cfg_wdata_i),
        .cfg_rdata_o   (cfg_rdata_o),
        .cfg_rvalid_o  (cfg_rvalid_o),
        .aw_hs_i       (aw_hs_i),
        .ar_hs_i       (ar_hs_i),
        .b_hs_i        (b_hs_i),
        .rlast_hs_i    (rlast_hs_i),
        .stall_o       (stall_o),
        .addr_map_o    (addr_map_o),
        .rule_valid_o  (rule_valid_o),
        .commit_done_o (commit_done_o)
    );

    int checks = 0;
    int errors = 0;

    // Reference model
    logic [63:0] m_sh_start  [N_RULES];
    logic [63:0] m_sh_end    [N_RULES];
    logic [2:0]  m_sh_idx    [N_RULES];
    logic        m_sh_valid  [N_RULES];
    logic [63:0] m_act_start [N_RULES];
    logic [63:0] m_act_end   [N_RULES];
    logic [2:0]  m_act_idx   [N_RULES];
    logic        m_act_valid [N_RULES];
    int          m_cnt;
    bit          m_cnt_err;
    bit          m_range_err;
    bit          m_commit_ok;

    typedef struct {
        bit                wr;
        logic [CFG_AW-1:0] addr;
        logic [63:0]       data;
        logic [63:0]       exp;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkb(input string name, input logic act, input logic exp);
        check(name, 64'(act), 64'(exp));
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic model_reset();
        for (int r = 0; r < N_RULES; r++) begin
            m_sh_start[r] = '0;
            m_sh_end[r]   = (r == 0) ? '1 : '0;
            m_sh_idx[r]   = (r == 0) ? 3'(DEFAULT_IDX) : 3'd0;
            m_sh_valid[r] = (r == 0);
            m_act_start[r] = m_sh_start[r];
            m_act_end[r]   = m_sh_end[r];
            m_act_idx[r]   = m_sh_idx[r];
            m_act_valid[r] = m_sh_valid[r];
        end
        m_cnt       = 0;
        m_cnt_err   = 0;
        m_range_err = 0;
        m_commit_ok = 0;
    endtask

    task automatic model_swap();
        for (int r = 0; r < N_RULES; r++) begin
            m_act_start[r] = m_sh_start[r];
            m_act_end[r]   = m_sh_end[r];
            m_act_idx[r]   = m_sh_idx[r];
            m_act_valid[r] = m_sh_valid[r];
        end
    endtask

    function automatic bit model_range_bad();
        for (int r = 0; r < N_RULES; r++) begin
            if (m_sh_valid[r] && (m_sh_start[r] > m_sh_end[r])) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_write(input logic [CFG_AW-1:0] addr, input logic [63:0] data);
        int r, f;
        r = int'(addr) / 4;
        f = int'(addr) % 4;
        if (addr == CTRL_ADDR) begin
            if (data[1]) begin
                m_range_err = 0;
                m_cnt_err   = 0;
            end
            if (data[0]) begin
                m_commit_ok = !model_range_bad();
                if (!m_commit_ok) m_range_err = 1;
            end
        end else if (r < N_RULES) begin
            case (f)
                0: m_sh_start[r] = data;
                1: m_sh_end[r]   = data;
                2: begin
                    m_sh_idx[r]   = data[2:0];
                    m_sh_valid[r] = data[3];
                end
                default: ;
            endcase
        end
    endtask

    function automatic logic [63:0] model_read(input int r, input int f);
        case (f)
            0: return m_sh_start[r];
            1: return m_sh_end[r];
            2: return {60'd0, m_sh_valid[r], m_sh_idx[r]};
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic [63:0] model_status(input bit busy);
        logic [63:0] s;
        s = 64'(m_cnt) << 3;
        s[0] = busy;
        s[1] = m_range_err;
        s[2] = m_cnt_err;
        return s;
    endfunction

    task automatic model_hs(input bit a, input bit b, input bit c, input bit d);
        m_cnt = m_cnt + int'(a) + int'(b) - int'(c) - int'(d);
        if (m_cnt < 0) begin
            m_cnt     = 0;
            m_cnt_err = 1;
        end else if (m_cnt > int'(2 * MAX_TXNS)) begin
            m_cnt     = int'(2 * MAX_TXNS);
            m_cnt_err = 1;
        end
    endtask

    task automatic hs(input bit a, input bit b, input bit c, input bit d);
        aw_hs_i = a; ar_hs_i = b; b_hs_i = c; rlast_hs_i = d;
        tick();
        aw_hs_i = 0; ar_hs_i = 0; b_hs_i = 0; rlast_hs_i = 0;
        model_hs(a, b, c, d);
    endtask

    task automatic cfg_wr(input logic [CFG_AW-1:0] addr, input logic [63:0] data);
        cfg_valid_i = 1; cfg_write_i = 1; cfg_addr_i = addr; cfg_wdata_i = data;
        tick();
        cfg_valid_i = 0; cfg_write_i = 0;
        model_write(addr, data);
    endtask

    task automatic cfg_rd(input logic [CFG_AW-1:0] addr, output logic [63:0] data);
        cfg_valid_i = 1; cfg_write_i = 0; cfg_addr_i = addr;
        tick();
        cfg_valid_i = 0;
        checkb("rvalid", cfg_rvalid_o, 1'b1);
        data = cfg_rdata_o;
    endtask

    task automatic check_active(input string tag);
        rule_t             ru;
        logic [N_RULES-1:0] vexp;
        for (int r = 0; r < N_RULES; r++) begin
            ru = addr_map_o[r*RULE_W +: RULE_W];
            check($sformatf("%s_start%0d", tag, r), ru.start_addr, m_act_start[r]);
            check($sformatf("%s_end%0d", tag, r), ru.end_addr, m_act_end[r]);
            check($sformatf("%s_idx%0d", tag, r), 64'(ru.idx), 64'(m_act_idx[r]));
            vexp[r] = m_act_valid[r];
        end
        check($sformatf("%s_valid", tag), 64'(rule_valid_o), 64'(vexp));
    endtask

    // Bounded wait for the swap pulse following an accepted commit.
    task automatic wait_commit(input string tag);
        for (int i = 0; i < 40; i++) begin
            if (commit_done_o) break;
            tick();
        end
        checkb($sformatf("%s_done_seen", tag), commit_done_o, 1'b1);
        if (commit_done_o) model_swap();
        check_active(tag);
    endtask

    function automatic vec_t mkv(input bit wr, input logic [CFG_AW-1:0] addr,
                                 input logic [63:0] data, input logic [63:0] exp);
        vec_t v;
        v.wr = wr; v.addr = addr; v.data = data; v.exp = exp;
        return v;
    endfunction

    initial begin
        logic [63:0] rd;
        vec_t        vecs[$];
        rule_t       ru;

        rst_i = 1; cfg_valid_i = 0; cfg_write_i = 0; cfg_addr_i = '0; cfg_wdata_i = '0;
        aw_hs_i = 0; ar_hs_i = 0; b_hs_i = 0; rlast_hs_i = 0;
        model_reset();
        repeat (3) tick();
        rst_i = 0;

        // Reset state
        checkb("rst_stall", stall_o, 1'b0);
        checkb("rst_rvalid", cfg_rvalid_o, 1'b0);
        check("rst_rdata", cfg_rdata_o, 64'd0);
        checkb("rst_done", commit_done_o, 1'b0);
        checkb("rst_ready", cfg_ready_o, 1'b1);
        check_active("rst");

        // Register-port vectors
        vecs.push_back(mkv(0, 7'd0,  64'd0, 64'd0));
        vecs.push_back(mkv(0, 7'd1,  64'd0, 64'hFFFF_FFFF_FFFF_FFFF));
        vecs.push_back(mkv(0, 7'd2,  64'd0, 64'h8));
        vecs.push_back(mkv(0, 7'd64, 64'd0, 64'd0));
        vecs.push_back(mkv(0, 7'd4,  64'd0, 64'd0));
        vecs.push_back(mkv(0, 7'd6,  64'd0, 64'd0));
        vecs.push_back(mkv(1, 7'd4,  64'h1000_0000, 64'd0));
        vecs.push_back(mkv(0, 7'd4,  64'd0, 64'h1000_0000));
        vecs.push_back(mkv(1, 7'd5,  64'h102F_FFFF, 64'd0));
        vecs.push_back(mkv(0, 7'd5,  64'd0, 64'h102F_FFFF));
        vecs.push_back(mkv(1, 7'd6,  64'hFFFF_0000_0000_000A, 64'd0));
        vecs.push_back(mkv(0, 7'd6,  64'd0, 64'hA));
        vecs.push_back(mkv(1, 7'd7,  64'h55, 64'd0));
        vecs.push_back(mkv(0, 7'd7,  64'd0, 64'd0));
        vecs.push_back(mkv(0, 7'd3,  64'd0, 64'd0));
        vecs.push_back(mkv(1, 7'd66, 64'hFF, 64'd0));
        vecs.push_back(mkv(0, 7'd66, 64'd0, 64'd0));
        vecs.push_back(mkv(0, 7'd2,  64'd0, 64'h8));
        foreach (vecs[i]) begin
            if (vecs[i].wr) begin
                cfg_wr(vecs[i].addr, vecs[i].data);
            end else begin
                cfg_rd(vecs[i].addr, rd);
                check($sformatf("vec%0d", i), rd, vecs[i].exp);
            end
        end

        // Minimum-latency commit: accept at 0, done at 3, stall during 1-2
        cfg_wr(CTRL_ADDR, 64'd1);
        checkb("c1_stall", stall_o, 1'b1);
        checkb("c1_done", commit_done_o, 1'b0);
        check("c1_valid", 64'(rule_valid_o), 64'h1);
        cfg_write_i = 1;
        #1;
        checkb("c1_wr_ready", cfg_ready_o, 1'b0);
        cfg_write_i = 0;
        #1;
        checkb("c1_rd_ready", cfg_ready_o, 1'b1);
        tick();
        checkb("c2_stall", stall_o, 1'b1);
        checkb("c2_done", commit_done_o, 1'b0);
        check("c2_valid", 64'(rule_valid_o), 64'h1);
        tick();
        checkb("c3_stall", stall_o, 1'b0);
        checkb("c3_done", commit_done_o, 1'b1);
        model_swap();
        ru = addr_map_o[1*RULE_W +: RULE_W];
        check("c3_r1_start", ru.start_addr, 64'h1000_0000);
        check("c3_r1_end", ru.end_addr, 64'h102F_FFFF);
        check("c3_r1_idx", 64'(ru.idx), 64'd2);
        check_active("c3");
        tick();
        checkb("c4_done", commit_done_o, 1'b0);

        // Commit with 3 AW + 2 AR outstanding
        repeat (3) hs(1, 0, 0, 0);
        repeat (2) hs(0, 1, 0, 0);
        cfg_rd(CTRL_ADDR, rd);
        check("out5_status", rd, 64'd40);
        cfg_wr(CTRL_ADDR, 64'd1);
        for (int i = 0; i < 4; i++) begin
            checkb($sformatf("drain_stall%0d", i), stall_o, 1'b1);
            tick();
        end
        cfg_rd(CTRL_ADDR, rd);
        check("drain_status", rd, 64'd41);
        hs(0, 0, 1, 1);
        hs(0, 0, 1, 1);
        hs(0, 0, 1, 0);
        checkb("cnt0_stall", stall_o, 1'b1);
        checkb("cnt0_done", commit_done_o, 1'b0);
        tick();
        checkb("cnt1_stall", stall_o, 1'b1);
        checkb("cnt1_done", commit_done_o, 1'b0);
        tick();
        checkb("cnt2_stall", stall_o, 1'b0);
        checkb("cnt2_done", commit_done_o, 1'b1);
        model_swap();
        check_active("drain");

        // Range error: rule 3 start > end
        cfg_wr(7'd12, 64'h2000);
        cfg_wr(7'd13, 64'h1000);
        cfg_wr(7'd14, 64'h9);
        cfg_wr(CTRL_ADDR, 64'd1);
        checkb("rng_stall0", stall_o, 1'b0);
        tick();
        checkb("rng_stall1", stall_o, 1'b0);
        cfg_rd(CTRL_ADDR, rd);
        check("rng_status", rd, 64'd2);
        check_active("rng");
        cfg_wr(CTRL_ADDR, 64'd2);
        cfg_rd(CTRL_ADDR, rd);
        check("rng_cleared", rd, 64'd0);
        cfg_wr(7'd14, 64'd0);

        // Counter underflow and overflow
        hs(0, 0, 1, 0);
        cfg_rd(CTRL_ADDR, rd);
        check("unf_status", rd, 64'd4);
        cfg_wr(CTRL_ADDR, 64'd2);
        repeat (2 * MAX_TXNS + 1) hs(1, 0, 0, 0);
        cfg_rd(CTRL_ADDR, rd);
        check("ovf_status", rd, 64'h104);
        cfg_wr(CTRL_ADDR, 64'd2);
        repeat (2 * MAX_TXNS) hs(0, 0, 1, 0);
        cfg_rd(CTRL_ADDR, rd);
        check("ovf_drained", rd, 64'd0);

        // Random handshake traffic vs. counter model, STATUS read every cycle
        for (int i = 0; i < 240; i++) begin
            int          up;
            bit          a, b, c, d;
            logic [63:0] exp;
            up = (i < 120) ? 3 : 1;
            a = ($urandom_range(0, 3) < up);
            b = ($urandom_range(0, 3) < up);
            c = ($urandom_range(0, 3) < (4 - up));
            d = ($urandom_range(0, 3) < (4 - up));
            aw_hs_i = a; ar_hs_i = b; b_hs_i = c; rlast_hs_i = d;
            cfg_valid_i = 1; cfg_write_i = 0; cfg_addr_i = CTRL_ADDR;
            exp = model_status(1'b0);
            model_hs(a, b, c, d);
            tick();
            checkb($sformatf("rnd_rvalid%0d", i), cfg_rvalid_o, 1'b1);
            check($sformatf("rnd_status%0d", i), cfg_rdata_o, exp);
        end
        aw_hs_i = 0; ar_hs_i = 0; b_hs_i = 0; rlast_hs_i = 0; cfg_valid_i = 0;
        cfg_wr(CTRL_ADDR, 64'd2);
        for (int i = 0; i < int'(2 * MAX_TXNS) && m_cnt > 0; i++) hs(0, 0, 1, 0);
        cfg_rd(CTRL_ADDR, rd);
        check("rnd_end_status", rd, model_status(1'b0));

        // Random shadow programming, read-back and commit
        for (int i = 0; i < 24; i++) begin
            int r, f;
            r = $urandom_range(1, N_RULES - 1);
            f = $urandom_range(0, 2);
            cfg_wr(7'(r * 4 + f), {$urandom, $urandom});
        end
        for (int r = 0; r < N_RULES; r++) begin
            for (int f = 0; f < 3; f++) begin
                cfg_rd(7'(r * 4 + f), rd);
                check($sformatf("rb_r%0d_f%0d", r, f), rd, model_read(r, f));
            end
        end
        cfg_wr(CTRL_ADDR, 64'd1);
        if (m_commit_ok) begin
            wait_commit("rnd1");
        end else begin
            checkb("rnd_bad_stall", stall_o, 1'b0);
            cfg_rd(CTRL_ADDR, rd);
            check("rnd_bad_status", rd, model_status(1'b0));
            cfg_wr(CTRL_ADDR, 64'd2);
            for (int r = 0; r < N_RULES; r++) begin
                if (m_sh_valid[r] && (m_sh_start[r] > m_sh_end[r])) cfg_wr(7'(r * 4 + 2), 64'd0);
            end
            cfg_wr(CTRL_ADDR, 64'd1);
            wait_commit("rnd2");
        end

        // Reset while draining
        hs(1, 0, 0, 0);
        cfg_wr(CTRL_ADDR, 64'd1);
        checkb("rstd_stall0", stall_o, 1'b1);
        tick();
        checkb("rstd_stall1", stall_o, 1'b1);
        rst_i = 1;
        tick();
        rst_i = 0;
        model_reset();
        checkb("rstd_stall", stall_o, 1'b0);
        checkb("rstd_done", commit_done_o, 1'b0);
        check_active("rstd");
        tick();
        checkb("rstd_done2", commit_done_o, 1'b0);
        checkb("rstd_stall2", stall_o, 1'b0);
        cfg_rd(CTRL_ADDR, rd);
        check("rstd_status", rd, 64'd0);
        cfg_rd(7'd4, rd);
        check("rstd_sh_r1", rd, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
